// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer for core.
// Streams Q rows into qmem and K rows into kmem, loads K into the array,
// executes the Q stream, then drains the output FIFO into pmem.
// Every output is registered, so no input reaches inst combinationally.
module core_inst_seq #(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [pr*bw-1:0] in_data,
  output logic             in_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [16:0]      inst,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE, QWR, QEND, KWR, KEND, SETTLE, KLOAD, KLEND,
    LOFF, GAP1, EXEC, XEND, GAP2, DRAIN, DEND
  } state_t;

  // Terminal counts; the counter is wide enough for the longest gap.
  localparam logic [9:0] TC_LAST  = 10'(total_cycle - 1);
  localparam logic [9:0] COL_LAST = 10'(col - 1);
  localparam logic [9:0] COL_N    = 10'(col);
  localparam logic [9:0] GAP_LAST = 10'(gap - 1);

  state_t     state;
  logic [9:0] cnt;
  logic       accept;
  logic [9:0] stream_last;

  assign accept      = in_valid & in_ready;
  assign stream_last = (state == KWR) ? COL_LAST : TC_LAST;

  // Assembles one instruction word; pmem_rd (bit 1) is never used.
  function automatic logic [16:0] pack_inst(
    input logic       ofifo_rd,
    input logic [3:0] qk_add,
    input logic [3:0] p_add,
    input logic       execute,
    input logic       load,
    input logic       qmem_rd,
    input logic       qmem_wr,
    input logic       kmem_rd,
    input logic       kmem_wr,
    input logic       pmem_wr
  );
    return {ofifo_rd, qk_add, p_add, execute, load, qmem_rd, qmem_wr,
            kmem_rd, kmem_wr, 1'b0, pmem_wr};
  endfunction

  // Sequencer FSM: each state registers the instruction for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      inst     <= '0;
      mem_in   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          inst <= '0;
          // done is still high in the first IDLE cycle, so a start then is ignored.
          if (start && !done) begin
            state    <= QWR;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        QWR, KWR: begin
          if (accept) begin
            mem_in <= in_data;
            inst   <= pack_inst(1'b0, cnt[3:0], 4'd0, 1'b0, 1'b0, 1'b0,
                                state == QWR, 1'b0, state == KWR, 1'b0);
            if (cnt == stream_last) begin
              in_ready <= 1'b0;
              cnt      <= '0;
              state    <= (state == QWR) ? QEND : KEND;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end else begin
            // A stall keeps the last address and row on the bus, write bits off.
            inst <= pack_inst(1'b0, inst[15:12], 4'd0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0);
          end
        end
        QEND: begin
          inst     <= '0;
          cnt      <= '0;
          in_ready <= 1'b1;
          state    <= KWR;
        end
        KEND: begin
          inst  <= '0;
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          inst <= '0;
          if (cnt == 10'd1) begin
            cnt   <= '0;
            state <= KLOAD;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        KLOAD: begin
          // The first load cycle carries no read; reads then trail the count by one.
          if (cnt == 10'd0) begin
            inst <= pack_inst(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0);
          end else begin
            inst <= pack_inst(1'b0, cnt[3:0] - 4'd1, 4'd0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b0, 1'b0);
          end
          if (cnt == COL_N) begin
            cnt   <= '0;
            state <= KLEND;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        KLEND: begin
          inst  <= pack_inst(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0);
          state <= LOFF;
        end
        LOFF: begin
          inst  <= '0;
          cnt   <= '0;
          state <= GAP1;
        end
        GAP1, GAP2: begin
          inst <= '0;
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= (state == GAP1) ? EXEC : DRAIN;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        EXEC: begin
          inst <= pack_inst(1'b0, cnt[3:0], 4'd0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0);
          if (cnt == TC_LAST) begin
            cnt   <= '0;
            state <= XEND;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        XEND: begin
          inst  <= '0;
          cnt   <= '0;
          state <= GAP2;
        end
        DRAIN: begin
          inst <= pack_inst(1'b1, 4'd0, cnt[3:0], 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1);
          if (cnt == TC_LAST) begin
            cnt   <= '0;
            state <= DEND;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DEND: begin
          inst  <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          inst     <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
